// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding and the fetch FSM state type.
// Consumers: fetch_stage (HALT handling under FETCH_HALT_EN), control decoder.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam logic [5:0] OPC_HALT  = 6'h3F;
  localparam logic [5:0] OPC_LW    = 6'd8;
  localparam logic [5:0] OPC_SW    = 6'd9;
  localparam logic [5:0] OPC_RTYPE = 6'd7;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:26] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry holding register for the fetch word that returns while the
// decoder is stalled. Load wins over clear.
module fetch_skid #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                clear_i,
  input  logic [31:0]         data_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic [31:0]         data_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                valid_o
);

  logic [31:0]         data_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle-latency program memory and
// presents one word per cycle to the decoder; a skid keeps the in-flight word
// across stalls. Define FETCH_HALT_EN to stop fetch on opcode 6'h3F.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd,
  input  logic [31:0]         imem_data,
  output logic [31:0]         Instruction,
  output logic                Instr_valid,
  output logic [PC_WIDTH-1:0] PC_out,
  output logic                halted
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] issued_pc_q, issued_pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                halted_q, halted_d;

  logic                skid_load, skid_clear, skid_valid;
  logic [31:0]         skid_data;
  logic [PC_WIDTH-1:0] skid_pc;

  logic                cap_en;
  logic [31:0]         cap_word;
  logic [PC_WIDTH-1:0] cap_pc;

  fetch_skid #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem_data),
    .pc_i    (issued_pc_q),
    .data_o  (skid_data),
    .pc_o    (skid_pc),
    .valid_o (skid_valid)
  );

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_out_d    = pc_out_q;
    halted_d    = halted_q;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    imem_rd     = 1'b0;
    cap_en      = 1'b0;
    cap_word    = imem_data;
    cap_pc      = issued_pc_q;

    case (state_q)
      FILL: begin
        imem_rd     = 1'b1;
        issued_pc_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + PC_WIDTH'(1);
        state_d     = RUN;
      end
      RUN: begin
        if (stall && valid_q) begin
          skid_load = 1'b1;
          state_d   = STALL;
        end else begin
          imem_rd     = 1'b1;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + PC_WIDTH'(1);
          cap_en      = 1'b1;
        end
      end
      STALL: begin
        if (!stall && skid_valid) begin
          imem_rd     = 1'b1;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + PC_WIDTH'(1);
          skid_clear  = 1'b1;
          cap_en      = 1'b1;
          cap_word    = skid_data;
          cap_pc      = skid_pc;
          state_d     = RUN;
        end
      end
      default: ;
    endcase

    // A HALT word is swallowed; the word issued alongside it is never captured.
    if (cap_en) begin
`ifdef FETCH_HALT_EN
      if (is_halt(cap_word)) begin
        instr_d  = NOP_INSTR;
        valid_d  = 1'b0;
        pc_out_d = cap_pc;
        halted_d = 1'b1;
        state_d  = HALT;
      end else begin
        instr_d  = cap_word;
        valid_d  = 1'b1;
        pc_out_d = cap_pc;
      end
`else
      instr_d  = cap_word;
      valid_d  = 1'b1;
      pc_out_d = cap_pc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      fetch_pc_q  <= PC_WIDTH'(RESET_PC);
      issued_pc_q <= '0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_addr   = fetch_pc_q;
  assign Instruction = instr_q;
  assign Instr_valid = valid_q;
  assign PC_out      = pc_out_q;
  assign halted      = halted_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and drives a synchronous-read program memory. It presents one 32-bit instruction word per cycle, with its address and a valid flag, on the `Instruction` bus that the decoder consumes. A downstream `stall` (e.g. multiplier busy) holds the presented word; a skid register preserves the word already in flight, so no instruction is dropped or duplicated.

## Interface
- `PC_WIDTH`, 8: word-address width of program memory; PC wraps modulo 2^PC_WIDTH.
- `RESET_PC`, 0: first word address fetched after reset.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `stall  in  1`: downstream hold request; honoured only while `Instr_valid`=1.
- `imem_addr  out  PC_WIDTH`: program-memory read address.
- `imem_rd  out  1`: read enable. When high, the memory returns `imem_data` for `imem_addr` on the following cycle.
- `imem_data  in  32`: program-memory read data, registered in memory, 1-cycle latency.
- `Instruction  out  32`: word presented to the control decoder. Registered.
- `Instr_valid  out  1`: `Instruction` is a real fetched word. When 0, `Instruction` is NOP (32'h0).
- `PC_out  out  PC_WIDTH`: word address of `Instruction`.
- `halted  out  1`: fetch stopped on a HALT word. Tied 0 without the macro.

## Operation
- FSM states: FILL, RUN, STALL, HALT.
- Internal registers:
  - `fetch_pc`: next address to issue.
  - `issued_pc`: address issued last cycle.
  - `skid_data`, `skid_pc`, `skid_valid`.
- Reset (sync, next edge):
  - state=FILL, `fetch_pc`=RESET_PC.
  - `Instruction`=32'h0, `Instr_valid`=0, `PC_out`=0, `halted`=0.
  - `skid_valid`=0.
  - Any in-flight return is discarded.
- Outputs are combinational from state: `imem_addr`=`fetch_pc`. `imem_rd`=1 in FILL, 1 in RUN unless (`stall` & `Instr_valid`), 1 in STALL only when `stall`=0, and 0 in HALT.
- FILL: issue `fetch_pc`, then `fetch_pc`++ and `issued_pc`←`fetch_pc`. Go to RUN. `stall` is ignored because `Instr_valid`=0.
- RUN, no hold (`stall`=0 or `Instr_valid`=0):
  - Capture `Instruction`←`imem_data`, `PC_out`←`issued_pc`, `Instr_valid`←1.
  - Issue the next address, `fetch_pc`++.
- RUN, hold (`stall`=1 and `Instr_valid`=1):
  - Outputs hold.
  - Returning word goes to the skid: `skid_data`←`imem_data`, `skid_pc`←`issued_pc`, `skid_valid`←1.
  - No issue this cycle. Go to STALL.
- STALL:
  - While `stall`=1: everything holds and `imem_rd`=0.
  - When `stall`=0: `Instruction`←`skid_data`, `PC_out`←`skid_pc`, `skid_valid`←0.
  - In the same cycle, issue `fetch_pc`, `fetch_pc`++. Go to RUN.
- Invariant: RUN always has exactly one return pending, and the skid is full exactly in STALL.
- Address arithmetic is unsigned modulo 2^PC_WIDTH: `fetch_pc` rolls from all-ones to 0 with no flag.
- `rst` has priority over `stall` and every other event in any state, including mid-STALL with the skid full.

## Timing
- First valid word: `Instruction`=mem[RESET_PC] with `Instr_valid`=1 on the 2nd rising edge after the first edge sampling `rst`=0.
- Throughput: 1 word/cycle when not stalled.
- `stall` asserted at edge N: `Instruction` and `PC_out` are unchanged at N and at every edge while it stays high.
- `stall` dropped (sampled 0) at edge M: the next sequential word appears at M. No bubble, no repeat.
- `stall` is sampled, never combinationally passed to outputs except `imem_rd`.

## Configuration
- Macro: `FETCH_HALT_EN`.
- Defined: a captured word with [31:26]=6'h3F (from `imem_data` in RUN or from the skid in STALL) is not presented.
  - Next edge: `Instruction`=32'h0, `Instr_valid`=0, `PC_out`=address of the HALT word, `halted`=1, state=HALT.
  - The word issued in the same cycle is discarded.
  - HALT holds until `rst`.
- Undefined: opcode 6'h3F passes through as an ordinary word. There is no HALT state and `halted` is constant 0.

## Structure
- Shared package `cpu_pkg` holds:
  - `NOP_INSTR`=32'h0.
  - `OPC_HALT`=6'h3F, `OPC_LW`=8, `OPC_SW`=9, `OPC_RTYPE`=7.
  - The fetch FSM state enum.
- One sub-module: `fetch_skid`, a single-entry data+pc holding register with load/clear and a valid flag.

## Test plan
- Sequential fetch: mem[0..3]=32'h1C221850, 32'h1C42182A, 32'h20410004, 32'h24410008; `rst` low → these words on 4 consecutive edges starting at the 2nd edge, `PC_out` 0,1,2,3, `Instr_valid`=1 throughout.
- Stall: hold `stall`=1 for 3 cycles while `PC_out`=1 → `Instruction`=32'h1C42182A held 3 cycles and `imem_rd`=0 in STALL. After release, `PC_out`=2 on the next edge with no duplicate.
- Wrap-around: `PC_WIDTH`=4, `RESET_PC`=14 → `PC_out` sequence 14,15,0,1.
- Reset mid-stall: `rst` pulsed while in STALL with the skid full → next edge `Instr_valid`=0 and `Instruction`=0. The skid word is never presented, and fetch restarts at RESET_PC.
- Stall during FILL: `stall`=1 from reset release → ignored, first word appears on schedule, then held.
- HALT: mem[2]=32'hFC000000.
  - With `FETCH_HALT_EN`: after `PC_out`=1, `Instr_valid`=0, `halted`=1, `PC_out`=2, and `imem_rd` stays 0.
  - Without: word presented with `Instr_valid`=1 and `halted`=0.
